// File: rtl/canny_pkg.sv
// Shared definitions for the Canny pipeline: pixel width, window width and
// the handshake state encoding used by the window generator and gradient stage.
package canny_pkg;

  localparam int PIX_W = 24;
  localparam int WIN_W = 9 * PIX_W;

  typedef enum logic [1:0] {
    ST_ACCEPT  = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2
  } win_state_e;

  function automatic int win_bits(input int pix_w);
    return 9 * pix_w;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// One-row delay line: a shift register of DEPTH samples that advances only
// when shift_en is high, so dout is the sample accepted DEPTH accepts ago.
module line_buffer #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 24
) (
  input  logic             clock,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] taps [DEPTH];

  always_ff @(posedge clock) begin
    if (shift_en) begin
      taps[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        taps[i] <= taps[i-1];
      end
    end
  end

  assign dout = taps[DEPTH-1];

endmodule

// File: rtl/window_3x3_gen.sv
// Raster-scan 3x3 window generator: two line buffers plus a 3x3 shift window,
// handing each complete window to the gradient stage with an Enable/done handshake.
module window_3x3_gen
  import canny_pkg::*;
#(
  parameter int PIX_W = canny_pkg::PIX_W,
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic                       Clock,
  input  logic                       reset,
  input  logic [PIX_W-1:0]           pixel_in,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [win_bits(PIX_W)-1:0] A,
  output logic                       Enable,
  input  logic                       done,
  output logic                       frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] C_MIN  = CW'(2);
  localparam logic [RW-1:0] R_MIN  = RW'(2);

  win_state_e                     state;
  logic [CW-1:0]                  col;
  logic [RW-1:0]                  row;
  logic [PIX_W-1:0]               row1_px;
  logic [PIX_W-1:0]               row2_px;
  logic [2:0][2:0][PIX_W-1:0]     win;
  logic [2:0][2:0][PIX_W-1:0]     win_nxt;
  logic                           accept;

  assign accept = in_valid && in_ready;

  line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb_row1 (
    .clock    (Clock),
    .shift_en (accept),
    .din      (pixel_in),
    .dout     (row1_px)
  );

  line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb_row2 (
    .clock    (Clock),
    .shift_en (accept),
    .din      (row1_px),
    .dout     (row2_px)
  );

  // Window shifts left; the new rightmost column is (r-2, r-1, r) at column c.
  always_comb begin
    win_nxt = win;
    for (int i = 0; i < 3; i++) begin
      win_nxt[i][0] = win[i][1];
      win_nxt[i][1] = win[i][2];
    end
    win_nxt[0][2] = row2_px;
    win_nxt[1][2] = row1_px;
    win_nxt[2][2] = pixel_in;
  end

  // Line buffers are never cleared: the row/column gate below keeps stale rows out of A.
  always_ff @(posedge Clock) begin
    if (reset) begin
      state      <= ST_ACCEPT;
      col        <= '0;
      row        <= '0;
      A          <= '0;
      Enable     <= 1'b0;
      frame_done <= 1'b0;
      in_ready   <= 1'b1;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        ST_ACCEPT: begin
          if (accept) begin
            win <= win_nxt;
            col <= (col == C_LAST) ? '0 : col + 1'b1;
            if (col == C_LAST) begin
              row <= (row == R_LAST) ? '0 : row + 1'b1;
            end
            if (row >= R_MIN && col >= C_MIN) begin
              A          <= win_nxt;
              Enable     <= 1'b1;
              in_ready   <= 1'b0;
              frame_done <= (row == R_LAST) && (col == C_LAST);
              state      <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (done) begin
            Enable <= 1'b0;
            state  <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          in_ready <= 1'b1;
          state    <= ST_ACCEPT;
        end
        default: begin
          Enable   <= 1'b0;
          in_ready <= 1'b1;
          state    <= ST_ACCEPT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_window_3x3_gen.sv
// Self-checking bench for window_3x3_gen on a 4x3 image: a frame-memory model
// pushes expected windows to a scoreboard that is drained as Enable rises.
module tb_window_3x3_gen;

  localparam int PW = 24;
  localparam int IW = 4;
  localparam int IH = 3;
  localparam int WW = 9 * PW;

  logic          Clock = 1'b0;
  logic          reset;
  logic [PW-1:0] pixel_in;
  logic          in_valid;
  logic          in_ready;
  logic [WW-1:0] A;
  logic          Enable;
  logic          done;
  logic          frame_done;

  typedef struct packed {
    logic [WW-1:0] win;
    logic          last;
  } exp_t;

  exp_t          sb_q [$];
  logic [WW-1:0] seen [$];
  logic [PW-1:0] img [IH][IW];
  int            mr = 0;
  int            mc = 0;
  int            checks = 0;
  int            errors = 0;
  int            done_delay = 2;
  logic          stray_req = 1'b0;

  always #5 Clock = ~Clock;

  window_3x3_gen #(.PIX_W(PW), .IMG_W(IW), .IMG_H(IH)) dut (
    .Clock      (Clock),
    .reset      (reset),
    .pixel_in   (pixel_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .A          (A),
    .Enable     (Enable),
    .done       (done),
    .frame_done (frame_done)
  );

  task automatic checkOutput(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [WW-1:0] pack9(input int p0, p1, p2, p3, p4, p5, p6, p7, p8);
    logic [WW-1:0] w;
    int v [9];
    v[0] = p0; v[1] = p1; v[2] = p2; v[3] = p3; v[4] = p4;
    v[5] = p5; v[6] = p6; v[7] = p7; v[8] = p8;
    w = '0;
    for (int k = 0; k < 9; k++) w[k*PW +: PW] = PW'(v[k]);
    return w;
  endfunction

  // Frame-memory model: the window is read straight out of the image array.
  task automatic modelAccept(input logic [PW-1:0] p);
    logic [WW-1:0] w;
    img[mr][mc] = p;
    if (mr >= 2 && mc >= 2) begin
      w = '0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          w[(i*3+j)*PW +: PW] = img[mr-2+i][mc-2+j];
      sb_q.push_back('{win: w, last: (mr == IH-1) && (mc == IW-1)});
    end
    if (mc == IW-1) begin
      mc = 0;
      mr = (mr == IH-1) ? 0 : mr + 1;
    end else begin
      mc++;
    end
  endtask

  task automatic applyStimulus(input logic [PW-1:0] p, input int gap);
    int waitc = 0;
    pixel_in = p;
    in_valid = 1'b1;
    while (!in_ready && waitc < 200) begin
      @(negedge Clock);
      waitc++;
    end
    if (!in_ready) checkOutput("accept_timeout", WW'(in_ready), WW'(1));
    else modelAccept(p);
    @(negedge Clock);
    in_valid = 1'b0;
    repeat (gap) @(negedge Clock);
  endtask

  task automatic sendFrame(input int base, input int gap);
    for (int k = 0; k < IW*IH; k++) applyStimulus(PW'(base + k), gap);
  endtask

  task automatic doReset();
    reset    = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge Clock);
    reset = 1'b0;
    mr = 0;
    mc = 0;
    checkOutput("reset_in_ready", WW'(in_ready), WW'(1));
    checkOutput("reset_enable", WW'(Enable), WW'(0));
    checkOutput("reset_frame_done", WW'(frame_done), WW'(0));
    checkOutput("reset_a", A, '0);
  endtask

  task automatic waitIdle();
    int waitc = 0;
    while ((sb_q.size() != 0 || Enable || !in_ready) && waitc < 200) begin
      @(negedge Clock);
      waitc++;
    end
    checkOutput("drain", WW'(sb_q.size()), WW'(0));
  endtask

  // Gradient-stage stand-in: returns done after done_delay cycles of Enable.
  initial begin
    int dcnt = 0;
    done = 1'b0;
    forever begin
      @(negedge Clock);
      if (Enable) begin
        dcnt++;
        done = (dcnt >= done_delay);
      end else begin
        dcnt = 0;
        done = stray_req;
        stray_req = 1'b0;
      end
    end
  end

  // Output monitor: scoreboard pop on Enable rise, hold and release checks.
  initial begin
    logic          enable_q = 1'b0;
    logic          rel_pending = 1'b0;
    logic [WW-1:0] held_a = '0;
    int            hold_len = 0;
    exp_t          e;
    forever begin
      @(negedge Clock);
      if (Enable && !enable_q) begin
        checkOutput("sb_has_entry", WW'(sb_q.size() > 0), WW'(1));
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          checkOutput("window", A, e.win);
          checkOutput("frame_done", WW'(frame_done), WW'(e.last));
        end
        seen.push_back(A);
        held_a   = A;
        hold_len = 1;
      end else if (Enable && enable_q) begin
        checkOutput("hold_a", A, held_a);
        checkOutput("hold_in_ready", WW'(in_ready), WW'(0));
        checkOutput("hold_frame_done", WW'(frame_done), WW'(0));
        hold_len++;
      end else if (!Enable && enable_q) begin
        checkOutput("hold_len", WW'(hold_len), WW'(done_delay));
        checkOutput("release_in_ready", WW'(in_ready), WW'(0));
        rel_pending = 1'b1;
      end else if (rel_pending) begin
        checkOutput("release_len", WW'(in_ready), WW'(1));
        rel_pending = 1'b0;
      end else if (frame_done) begin
        checkOutput("stray_frame_done", WW'(frame_done), WW'(0));
      end
      enable_q = Enable;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [WW-1:0] w;
    logic [WW-1:0] win_a;
    logic [WW-1:0] win_b;
    win_a = pack9(1, 2, 3, 5, 6, 7, 9, 10, 11);
    win_b = pack9(2, 3, 4, 6, 7, 8, 10, 11, 12);
    reset    = 1'b1;
    in_valid = 1'b0;
    pixel_in = '0;
    repeat (3) @(negedge Clock);
    doReset();

    $display("[TB] basic frame 1..12");
    done_delay = 2;
    seen.delete();
    sendFrame(1, 0);
    waitIdle();
    checkOutput("t1_count", WW'(seen.size()), WW'(2));
    w = seen[0];
    checkOutput("t1_a_lo", WW'(w[23:0]), WW'(1));
    checkOutput("t1_a_hi", WW'(w[215:192]), WW'(11));
    checkOutput("t1_win0", seen[0], win_a);
    checkOutput("t1_win1", seen[1], win_b);

    $display("[TB] done withheld");
    done_delay = 6;
    seen.delete();
    sendFrame(1, 0);
    waitIdle();
    checkOutput("t2_count", WW'(seen.size()), WW'(2));
    checkOutput("t2_win1", seen[1], win_b);

    $display("[TB] reset mid-frame");
    done_delay = 2;
    for (int k = 1; k <= 6; k++) applyStimulus(PW'(k), 0);
    doReset();
    seen.delete();
    sendFrame(1, 0);
    waitIdle();
    checkOutput("t3_count", WW'(seen.size()), WW'(2));
    checkOutput("t3_win0", seen[0], win_a);
    checkOutput("t3_win1", seen[1], win_b);

    $display("[TB] back-to-back frames");
    seen.delete();
    sendFrame(1, 0);
    sendFrame(101, 0);
    waitIdle();
    checkOutput("t4_count", WW'(seen.size()), WW'(4));
    checkOutput("t4_win2", seen[2], pack9(101, 102, 103, 105, 106, 107, 109, 110, 111));

    $display("[TB] sparse valid with stray done");
    seen.delete();
    for (int k = 1; k <= 5; k++) applyStimulus(PW'(k), 1);
    stray_req = 1'b1;
    repeat (3) @(negedge Clock);
    checkOutput("t5_stray_ready", WW'(in_ready), WW'(1));
    checkOutput("t5_stray_enable", WW'(Enable), WW'(0));
    for (int k = 6; k <= 12; k++) applyStimulus(PW'(k), 1);
    waitIdle();
    checkOutput("t5_count", WW'(seen.size()), WW'(2));
    checkOutput("t5_win0", seen[0], win_a);
    checkOutput("t5_win1", seen[1], win_b);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
